// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage data-memory path.
// State, access-size and byte-enable encodings.
package mips_mem_pkg;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_BU,
    SZ_H,
    SZ_W
  } size_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Load lane extractor with sign/zero extension.
// Purely combinational; reusable for line-fill paths.
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  size_t       i_size,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;

  // pick the addressed byte and halfword lanes
  always_comb begin
    w_b = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_b = i_rdata[7:0];
      2'd1: w_b = i_rdata[15:8];
      2'd2: w_b = i_rdata[23:16];
      2'd3: w_b = i_rdata[31:24];
    endcase
    w_h = i_off[1] ? i_rdata[31:16]
                   : i_rdata[15:0];
  end

  // extend the selected lane to 32 bits
  always_comb begin
    o_data = i_rdata;
    unique case (i_size)
      SZ_B:  o_data = {{24{w_b[7]}}, w_b};
      SZ_BU: o_data = {24'b0, w_b};
      SZ_H:  o_data = {{16{w_h[15]}}, w_h};
      SZ_W:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit.
// Req/ack bus master, lane steering, WB register.
module dmem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset_,
  input  logic              Byte,
  input  logic              ByteU,
  input  logic              HalfWord,
  input  logic              Word,
  input  logic              StoreByte,
  input  logic              StoreHalfWord,
  input  logic              StoreWord,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] StoreData,
  output logic              Stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] LoadData_reg,
  output logic [DATA_W-1:0] AluResult_reg,
  output logic              MemtoReg_reg,
  output logic              RegWrite_reg,
  output logic              MisalignErr_reg
);

  state_t r_state;
  state_t w_next;

  size_t w_ld_sz;
  size_t w_st_sz;
  size_t w_sz;

  logic              w_valid;
  logic              w_mis;
  logic              w_start;
  logic              w_ack;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ld;

  // resolve load/store size with fixed precedence
  always_comb begin
    w_ld_sz = SZ_BU;
    if (Word)          w_ld_sz = SZ_W;
    else if (HalfWord) w_ld_sz = SZ_H;
    else if (Byte)     w_ld_sz = SZ_B;
    w_st_sz = SZ_B;
    if (StoreWord)          w_st_sz = SZ_W;
    else if (StoreHalfWord) w_st_sz = SZ_H;
    w_sz = MemWrite ? w_st_sz : w_ld_sz;
  end

  assign w_valid = MemRead ^ MemWrite;
  assign w_mis   = w_valid
                 & (((w_sz == SZ_H) & Addr[0])
                 | ((w_sz == SZ_W) & (Addr[1:0] != 2'b00)));
  assign w_start = w_valid & ~w_mis;
  assign w_ack   = (r_state == REQ) & dmem_ack;

  assign Stall = ((r_state == IDLE) & w_start)
               | ((r_state == REQ) & ~dmem_ack);

  // byte enables and lane-replicated store data
  always_comb begin
    w_be    = BE_BYTE << Addr[1:0];
    w_wdata = {4{StoreData[7:0]}};
    unique case (w_sz)
      SZ_W:    w_be = BE_WORD;
      SZ_H:    w_be = BE_HALF << {Addr[1], 1'b0};
      default: w_be = BE_BYTE << Addr[1:0];
    endcase
    unique case (w_st_sz)
      SZ_W:    w_wdata = StoreData;
      SZ_H:    w_wdata = {2{StoreData[15:0]}};
      default: w_wdata = {4{StoreData[7:0]}};
    endcase
  end

  load_align u_load_align (
    .i_rdata (dmem_rdata),
    .i_off   (Addr[1:0]),
    .i_size  (w_ld_sz),
    .o_data  (w_ld)
  );

  // FSM state register
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start)  w_next = REQ;
      REQ:  if (dmem_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // bus outputs: load on launch, hold until ack
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= 4'b0000;
      dmem_wdata <= '0;
    end else if ((r_state == IDLE) && w_start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWrite;
      dmem_addr  <= {Addr[ADDR_W-1:2], 2'b00};
      dmem_be    <= w_be;
      dmem_wdata <= w_wdata;
    end else if (w_ack) begin
      dmem_req   <= 1'b0;
    end
  end

  // MEM/WB register; bubble while stalled
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      LoadData_reg    <= '0;
      AluResult_reg   <= '0;
      MemtoReg_reg    <= 1'b0;
      RegWrite_reg    <= 1'b0;
      MisalignErr_reg <= 1'b0;
    end else if (!Stall) begin
      LoadData_reg    <= (w_ack & ~dmem_we) ? w_ld : '0;
      AluResult_reg   <= DATA_W'(Addr);
      MemtoReg_reg    <= MemtoReg;
      RegWrite_reg    <= RegWrite & ~w_mis;
      MisalignErr_reg <= w_mis;
    end else begin
      MemtoReg_reg    <= 1'b0;
      RegWrite_reg    <= 1'b0;
      MisalignErr_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scoreboard bench for dmem_access_unit.
// Expected WB bundles are queued at issue, popped after.
module tb_dmem_access_unit;
  import mips_mem_pkg::*;

  typedef struct packed {
    logic b, bu, h, w, sb, sh, sw;
    logic mr, mw, m2r, rw;
    logic [31:0] addr;
    logic [31:0] sd;
  } ins_t;

  typedef struct packed {
    logic [31:0] ld;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic        seen;
    logic        held;
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  stalls;
  } bus_t;

  logic        Clock = 1'b0;
  logic        Reset_ = 1'b0;
  logic        Byte, ByteU, HalfWord, Word;
  logic        StoreByte, StoreHalfWord, StoreWord;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic [31:0] Addr, StoreData;
  logic        Stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] LoadData_reg, AluResult_reg;
  logic        MemtoReg_reg, RegWrite_reg, MisalignErr_reg;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  dmem_access_unit dut (
    .Clock(Clock), .Reset_(Reset_),
    .Byte(Byte), .ByteU(ByteU),
    .HalfWord(HalfWord), .Word(Word),
    .StoreByte(StoreByte),
    .StoreHalfWord(StoreHalfWord),
    .StoreWord(StoreWord),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Addr(Addr), .StoreData(StoreData),
    .Stall(Stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .LoadData_reg(LoadData_reg),
    .AluResult_reg(AluResult_reg),
    .MemtoReg_reg(MemtoReg_reg),
    .RegWrite_reg(RegWrite_reg),
    .MisalignErr_reg(MisalignErr_reg)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] m_load(
    logic [31:0] rd, logic [1:0] off, int k);
    logic [31:0] s;
    s = rd >> (8 * off);
    case (k)
      0: return {{24{s[7]}}, s[7:0]};
      1: return {24'b0, s[7:0]};
      2: return {{16{s[15]}}, s[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic int ld_kind(ins_t x);
    if (x.w) return 3;
    if (x.h) return 2;
    if (x.b) return 0;
    return 1;
  endfunction

  function automatic logic m_mis(ins_t x);
    int k;
    if (!(x.mr ^ x.mw)) return 1'b0;
    if (x.mw) k = x.sw ? 3 : (x.sh ? 2 : 0);
    else      k = ld_kind(x);
    if (k == 3) return x.addr[1:0] != 2'b00;
    if (k == 2) return x.addr[0];
    return 1'b0;
  endfunction

  function automatic exp_t m_wb(ins_t x, logic [31:0] rd);
    exp_t e;
    e.err = m_mis(x);
    e.alu = x.addr;
    e.m2r = x.m2r;
    e.rw  = x.rw & ~e.err;
    e.ld  = '0;
    if (x.mr && !x.mw && !e.err)
      e.ld = m_load(rd, x.addr[1:0], ld_kind(x));
    return e;
  endfunction

  function automatic logic [35:0] m_store(ins_t x);
    if (x.sw) return {4'b1111, x.sd};
    if (x.sh)
      return {(x.addr[1] ? 4'b1100 : 4'b0011),
              x.sd[15:0], x.sd[15:0]};
    return {4'b0001 << x.addr[1:0],
            x.sd[7:0], x.sd[7:0], x.sd[7:0], x.sd[7:0]};
  endfunction

  task automatic drive(input ins_t x);
    Byte = x.b; ByteU = x.bu;
    HalfWord = x.h; Word = x.w;
    StoreByte = x.sb; StoreHalfWord = x.sh;
    StoreWord = x.sw;
    MemRead = x.mr; MemWrite = x.mw;
    MemtoReg = x.m2r; RegWrite = x.rw;
    Addr = x.addr; StoreData = x.sd;
  endtask

  // call at a negedge; returns at posedge+1 after WB load
  task automatic issue(input ins_t x, input int dly,
                       input logic [31:0] rd,
                       output bus_t bo);
    int rc;
    logic done;
    rc = 0;
    done = 1'b0;
    bo = '0;
    bo.held = 1'b1;
    drive(x);
    for (int i = 0; i < 64 && !done; i++) begin
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (dmem_req) begin
        if (!bo.seen) begin
          bo.seen = 1'b1;
          bo.a = dmem_addr; bo.be = dmem_be;
          bo.wd = dmem_wdata; bo.we = dmem_we;
        end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we}
                     !== {bo.a, bo.be, bo.wd, bo.we})
          bo.held = 1'b0;
        if (rc == dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd;
        end
        rc++;
      end
      #1;
      if (!Stall) done = 1'b1;
      else begin
        bo.stalls = bo.stalls + 8'd1;
        @(negedge Clock);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: Stall never cleared");
    end
    @(posedge Clock);
    #1;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset;
    ins_t x;
    x = '0;
    drive(x);
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    #12;
    checks++;
    if ({Stall, dmem_req, dmem_we, dmem_addr, dmem_be,
         dmem_wdata, LoadData_reg, AluResult_reg,
         MemtoReg_reg, RegWrite_reg, MisalignErr_reg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b be=%b ld=%h alu=%h want all 0",
               dmem_req, dmem_be, LoadData_reg, AluResult_reg);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want IDLE", dut.r_state);
    end
    @(negedge Clock);
    Reset_ = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_sw;
    ins_t x; bus_t b; exp_t e, g;
    x = '0; x.sw = 1; x.mw = 1;
    x.addr = 32'h100; x.sd = 32'hDEADBEEF;
    sbq.push_back(m_wb(x, '0));
    issue(x, 1, '0, b);
    checks++;
    if ({b.seen, b.we, b.a, b.be, b.wd} !==
        {1'b1, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_bus: got seen=%b we=%b a=%h be=%b wd=%h want 1 1 100 1111 deadbeef",
               b.seen, b.we, b.a, b.be, b.wd);
    end
    checks++;
    if (b.stalls !== 8'd2 || !b.held) begin
      errors++;
      $display("FAIL sw_stall: got stalls=%0d held=%b want 2 1",
               b.stalls, b.held);
    end
    e = sbq.pop_front();
    g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
         RegWrite_reg, MisalignErr_reg};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL sw_wb: got %h want %h", g, e);
    end
    @(negedge Clock);
  endtask

  task automatic test_sb;
    ins_t x; bus_t b; exp_t e, g;
    x = '0; x.sb = 1; x.mw = 1;
    x.addr = 32'h103; x.sd = 32'h000000A5;
    sbq.push_back(m_wb(x, '0));
    issue(x, 0, '0, b);
    checks++;
    if ({b.seen, b.a, b.be, b.wd} !==
        {1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_bus: got a=%h be=%b wd=%h want 100 1000 a5a5a5a5",
               b.a, b.be, b.wd);
    end
    e = sbq.pop_front();
    g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
         RegWrite_reg, MisalignErr_reg};
    checks++;
    if (g !== e || RegWrite_reg !== 1'b0) begin
      errors++;
      $display("FAIL sb_wb: got %h want %h", g, e);
    end
    @(negedge Clock);
  endtask

  task automatic test_lb;
    ins_t x; bus_t b; exp_t e;
    logic [31:0] want [2];
    want[0] = 32'hFFFFFFF4;
    want[1] = 32'h000000F4;
    for (int u = 0; u < 2; u++) begin
      x = '0; x.mr = 1; x.m2r = 1; x.rw = 1;
      x.addr = 32'h202;
      if (u == 0) x.b = 1;
      else        x.bu = 1;
      sbq.push_back(m_wb(x, 32'h12F45678));
      issue(x, 0, 32'h12F45678, b);
      checks++;
      if (b.stalls !== 8'd1 || b.we !== 1'b0 ||
          b.a !== 32'h200) begin
        errors++;
        $display("FAIL lb_bus%0d: got stalls=%0d we=%b a=%h want 1 0 200",
                 u, b.stalls, b.we, b.a);
      end
      e = sbq.pop_front();
      checks++;
      if (LoadData_reg !== want[u] || LoadData_reg !== e.ld ||
          RegWrite_reg !== 1'b1 || MemtoReg_reg !== 1'b1) begin
        errors++;
        $display("FAIL lb_data%0d: got %h rw=%b want %h rw=1",
                 u, LoadData_reg, RegWrite_reg, want[u]);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_misalign;
    ins_t x; bus_t b; exp_t e, g;
    x = '0; x.h = 1; x.mr = 1; x.m2r = 1; x.rw = 1;
    x.addr = 32'h301;
    sbq.push_back(m_wb(x, '0));
    issue(x, 0, '0, b);
    checks++;
    if (b.seen !== 1'b0 || b.stalls !== 8'd0) begin
      errors++;
      $display("FAIL mis_bus: got req=%b stalls=%0d want 0 0",
               b.seen, b.stalls);
    end
    e = sbq.pop_front();
    g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
         RegWrite_reg, MisalignErr_reg};
    checks++;
    if (g !== e || MisalignErr_reg !== 1'b1 ||
        RegWrite_reg !== 1'b0) begin
      errors++;
      $display("FAIL mis_wb: got %h want %h", g, e);
    end
    @(negedge Clock);
    x = '0; x.addr = 32'h44;
    sbq.push_back(m_wb(x, '0));
    issue(x, 0, '0, b);
    e = sbq.pop_front();
    checks++;
    if (MisalignErr_reg !== e.err || e.err !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear: got err=%b want 0", MisalignErr_reg);
    end
    @(negedge Clock);
  endtask

  task automatic test_nonmem;
    ins_t x; bus_t b; exp_t e, g;
    for (int s = 0; s < 2; s++) begin
      x = '0;
      if (s == 0) begin
        x.mr = 1; x.mw = 1; x.addr = 32'h0;
      end else begin
        x.rw = 1; x.addr = 32'h1234;
      end
      sbq.push_back(m_wb(x, '0));
      issue(x, 0, '0, b);
      checks++;
      if (b.seen !== 1'b0 || b.stalls !== 8'd0) begin
        errors++;
        $display("FAIL nonmem_bus%0d: got req=%b stalls=%0d want 0 0",
                 s, b.seen, b.stalls);
      end
      e = sbq.pop_front();
      g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
           RegWrite_reg, MisalignErr_reg};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL nonmem_wb%0d: got %h want %h", s, g, e);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_ack_idle;
    ins_t x;
    x = '0; x.rw = 1; x.addr = 32'h88;
    drive(x);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(posedge Clock);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || LoadData_reg !== 32'h0 ||
        dut.r_state !== IDLE || AluResult_reg !== 32'h88) begin
      errors++;
      $display("FAIL ack_idle: got req=%b ld=%h alu=%h want 0 0 88",
               dmem_req, LoadData_reg, AluResult_reg);
    end
    dmem_ack = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_sweep;
    ins_t x; bus_t b; exp_t e, g;
    logic [31:0] rd;
    logic [35:0] st;
    int dly;
    for (int k = 0; k < 9; k++) begin
      for (int off = 0; off < 4; off++) begin
        x = '0;
        x.addr = 32'h600 + 32'(k * 16) + 32'(off);
        x.sd = $urandom;
        if (k < 4 || k == 7) begin
          x.mr = 1; x.m2r = 1; x.rw = 1;
        end else x.mw = 1;
        case (k)
          0: x.b = 1;
          1: x.bu = 1;
          2: x.h = 1;
          3: x.w = 1;
          4: x.sb = 1;
          5: x.sh = 1;
          6: x.sw = 1;
          7: begin x.w = 1; x.b = 1; end
          default: begin x.sw = 1; x.sh = 1; x.sb = 1; end
        endcase
        rd = $urandom;
        dly = $urandom_range(0, 2);
        e = m_wb(x, rd);
        sbq.push_back(e);
        issue(x, dly, rd, b);
        checks++;
        if (e.err) begin
          if (b.seen !== 1'b0 || b.stalls !== 8'd0) begin
            errors++;
            $display("FAIL sweep_mis k%0d o%0d: got req=%b stalls=%0d want 0 0",
                     k, off, b.seen, b.stalls);
          end
        end else if (b.seen !== 1'b1 || !b.held ||
                     b.stalls !== 8'(dly + 1) ||
                     b.a !== {x.addr[31:2], 2'b00} ||
                     b.we !== x.mw) begin
          errors++;
          $display("FAIL sweep_bus k%0d o%0d: got a=%h we=%b stalls=%0d want a=%h stalls=%0d",
                   k, off, b.a, b.we, b.stalls,
                   {x.addr[31:2], 2'b00}, dly + 1);
        end
        if (x.mw && !e.err) begin
          st = m_store(x);
          checks++;
          if ({b.be, b.wd} !== st) begin
            errors++;
            $display("FAIL sweep_st k%0d o%0d: got be=%b wd=%h want be=%b wd=%h",
                     k, off, b.be, b.wd, st[35:32], st[31:0]);
          end
        end
        e = sbq.pop_front();
        g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
             RegWrite_reg, MisalignErr_reg};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL sweep_wb k%0d o%0d: got %h want %h",
                   k, off, g, e);
        end
        @(negedge Clock);
      end
    end
  endtask

  task automatic test_back_to_back;
    ins_t x [2]; bus_t b; exp_t e, g;
    x[0] = '0; x[0].w = 1; x[0].mr = 1; x[0].rw = 1;
    x[0].addr = 32'h400;
    x[1] = '0; x[1].h = 1; x[1].mr = 1; x[1].rw = 1;
    x[1].addr = 32'h402;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(m_wb(x[i], 32'h8001_7FFE + 32'(i)));
      issue(x[i], 0, 32'h8001_7FFE + 32'(i), b);
      checks++;
      if (b.stalls !== 8'd1) begin
        errors++;
        $display("FAIL b2b_stall%0d: got %0d want 1", i, b.stalls);
      end
      e = sbq.pop_front();
      g = {LoadData_reg, AluResult_reg, MemtoReg_reg,
           RegWrite_reg, MisalignErr_reg};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_wb%0d: got %h want %h", i, g, e);
      end
      @(negedge Clock);
    end
  endtask

  task automatic test_reset_mid_req;
    ins_t x;
    x = '0; x.w = 1; x.mr = 1; x.rw = 1; x.m2r = 1;
    x.addr = 32'h500;
    drive(x);
    dmem_ack = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    #2;
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got req=%b want 1", dmem_req);
    end
    Reset_ = 1'b0;
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
         LoadData_reg, AluResult_reg, MemtoReg_reg,
         RegWrite_reg, MisalignErr_reg} !== '0 ||
        dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL rst_mid: got req=%b be=%b alu=%h rw=%b want all 0 IDLE",
               dmem_req, dmem_be, AluResult_reg, RegWrite_reg);
    end
    x = '0;
    drive(x);
    @(negedge Clock);
    Reset_ = 1'b1;
    @(posedge Clock);
    #1;
    checks++;
    if (RegWrite_reg !== 1'b0 || dmem_req !== 1'b0 ||
        LoadData_reg !== 32'h0) begin
      errors++;
      $display("FAIL rst_after: got rw=%b req=%b ld=%h want 0 0 0",
               RegWrite_reg, dmem_req, LoadData_reg);
    end
    @(negedge Clock);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lb();
    test_misalign();
    test_nonmem();
    test_ack_idle();
    test_sweep();
    test_back_to_back();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-memory access unit for the 5-stage MIPS pipeline. It consumes the registered load/store size and memory controls produced by the decode-side control unit, drives a variable-latency request/acknowledge data-memory bus, and holds the pipeline with `Stall` until the access completes. It performs byte-lane steering and byte enables for stores, lane extraction and sign/zero extension for loads, and misalignment detection. Results are registered into the MEM/WB boundary.

## Interface
Parameters:
- `DATA_W`, default 32: data width. Fixed at 32; byte-lane logic assumes 4 lanes.
- `ADDR_W`, default 32: address width.

Ports:
- `Clock`  in  1  clock; all state updates on the rising edge.
- `Reset_`  in  1  reset, asynchronous, active-low.
- `Byte`, `ByteU`, `HalfWord`, `Word`  in  1 each  load size/sign selects, from the EX/MEM register.
- `StoreByte`, `StoreHalfWord`, `StoreWord`  in  1 each  store size selects.
- `MemRead`, `MemWrite`, `MemtoReg`, `RegWrite`  in  1 each  memory and writeback controls.
- `Addr`  in  ADDR_W  effective address (ALU result).
- `StoreData`  in  DATA_W  Rt value to store.
- `Stall`  out  1  freeze the IF/ID/EX/MEM registers (combinational).
- `dmem_req`  out  1  bus request (registered).
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  ADDR_W  word address; bits [1:0] are always 0.
- `dmem_be`  out  4  byte enables; lane k = bits [8k+7:8k], little-endian.
- `dmem_wdata`  out  DATA_W  lane-steered store data.
- `dmem_rdata`  in  DATA_W  read data; valid in the cycle `dmem_ack`=1.
- `dmem_ack`  in  1  access complete.
- `LoadData_reg`, `AluResult_reg`  out  DATA_W  values passed to WB.
- `MemtoReg_reg`, `RegWrite_reg`, `MisalignErr_reg`  out  1  registered to WB.

## Operation
- An access is valid when MemRead XOR MemWrite is 1.
  - If both are 1 (the control unit's reset pattern) or both are 0, the instruction is treated as a non-memory instruction.
- Size precedence when more than one select is set:
  - Loads: Word > HalfWord > Byte > ByteU.
  - Stores: StoreWord > StoreHalfWord > StoreByte.
- Misalignment:
  - A halfword access is misaligned when Addr[0] = 1.
  - A word access is misaligned when Addr[1:0] ≠ 0.
  - On a misaligned access: no bus request, no stall, `MisalignErr_reg` = 1 for one cycle, `RegWrite_reg` forced to 0.
- Store steering:
  - Byte: be = 4'b0001 << Addr[1:0]; wdata = StoreData[7:0] replicated ×4.
  - Halfword: be = 4'b0011 << {Addr[1],1'b0}; wdata = StoreData[15:0] replicated ×2.
  - Word: be = 4'b1111; wdata = StoreData.
- Load extraction selects the lane(s) addressed by Addr[1:0]:
  - Byte and HalfWord sign-extend.
  - ByteU zero-extends.
  - Word passes through unchanged.
- FSM states and transitions:
  - IDLE → REQ on a valid, aligned access. On that edge, `dmem_addr`, `dmem_be`, `dmem_we` and `dmem_wdata` are loaded; `dmem_req` goes to 1.
  - REQ: holds all bus outputs constant until `dmem_ack` = 1; then → IDLE and `dmem_req` drops.
  - Non-memory and misaligned instructions stay in IDLE.
- `Stall` = (IDLE & valid & aligned) | (REQ & !dmem_ack).
- WB registers (`LoadData_reg`, `AluResult_reg`, `MemtoReg_reg`, `RegWrite_reg`, `MisalignErr_reg`) load on every edge where `Stall` = 0. `AluResult_reg` takes `Addr`. `LoadData_reg` takes the extracted load data on a load-ack edge and is 0 otherwise.
- While `Stall` = 1, the WB registers load a bubble: `RegWrite_reg` = 0, `MemtoReg_reg` = 0, `MisalignErr_reg` = 0, data held.
- Reset values:
  - All outputs 0; `dmem_be` = 4'b0000.
  - State IDLE.
- Boundary conditions:
  - `dmem_ack` outside REQ is ignored.
  - Reset asserted mid-REQ drops `dmem_req` asynchronously and abandons the access; no WB write occurs.
  - A back-to-back memory instruction after completion starts from IDLE on the following cycle.

## Timing
- Non-memory instruction: no stall; WB registers updated one edge after the inputs are presented.
- Memory access with a zero-wait-state bus (ack in the first REQ cycle): `Stall` high for 1 cycle; result reaches WB 2 edges after presentation.
- Each cycle of ack delay adds one cycle of `Stall`.
- Inputs must stay constant while `Stall` = 1; the upstream register guarantees this.

## Structure
- Shared package `mips_mem_pkg` holds:
  - the state typedef (IDLE, REQ);
  - the byte-enable constants BE_BYTE, BE_HALF, BE_WORD;
  - the size encoding enum (SZ_B, SZ_BU, SZ_H, SZ_W).
- One natural sub-module: `load_align`, a combinational lane extractor and sign/zero extender (rdata, Addr[1:0], size → 32-bit result). It is reusable by a future cache line-fill path.

## Test plan
- SW, Addr=0x100, StoreData=0xDEADBEEF, ack one cycle after req → be=4'b1111, wdata=0xDEADBEEF, dmem_addr=0x100, Stall high exactly 2 cycles.
- SB, Addr=0x103, StoreData=0x000000A5 → be=4'b1000, wdata=0xA5A5A5A5, `RegWrite_reg`=0.
- LB, Addr=0x202, rdata=0x12F45678, ack in first REQ cycle → `LoadData_reg`=0xFFFFFFF4; LBU with the same stimulus → 0x000000F4.
- Halfword load, Addr=0x301 → no `dmem_req`, no Stall, `MisalignErr_reg`=1 for 1 cycle, `RegWrite_reg`=0.
- MemRead=MemWrite=1 (post-reset pattern), then an R-type with RegWrite=1 → no request, `RegWrite_reg`=1 one edge later.
- LW with ack withheld for 5 cycles, `Reset_` pulsed low in cycle 3 → `dmem_req` falls immediately, state IDLE, all outputs 0, no WB write.
